// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// Resolves control transfers for the EX-stage instruction. It owns the fetch
// PC, redirects fetch on taken branches and jumps, and then squashes the IF
// and ID slots for FLUSH_CYCLES unstalled cycles.
//
// Parameters
//   RESET_PC      value loaded into the fetch PC on reset
//   FLUSH_CYCLES  cycles flush_o stays high after a redirect (1..7)
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   stall_i       pipeline hold: freezes PC and flush counter, no resolution
//   valid_i       EX instruction is valid
//   is_branch_i   EX instruction is a conditional branch
//   is_jal_i      EX instruction is JAL
//   is_jalr_i     EX instruction is JALR
//   funct3_i      branch condition code
//   br_less_i     comparator: rs1 < rs2
//   br_equal_i    comparator: rs1 == rs2
//   pc_ex_i       PC of the EX instruction
//   imm_i         sign-extended branch / JAL offset
//   jalr_tgt_i    rs1 + imm sum from the ALU
//   br_unsign_o   comparator unsigned-mode select (combinational)
//   pc_o          registered fetch PC
//   redirect_o    combinational; control transfer taken this cycle
//   target_o      combinational resolved target
//   flush_o       registered; squash IF and ID
//   misalign_o    registered pulse: taken transfer had a misaligned target
//   illegal_o     registered pulse: branch with reserved funct3 (010/011)
//   br_cnt_o      count of resolved legal branches
//   taken_cnt_o   count of redirects caused by branches
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic        is_branch_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [2:0]  funct3_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] jalr_tgt_i,
    output logic        br_unsign_o,
    output logic [31:0] pc_o,
    output logic        redirect_o,
    output logic [31:0] target_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic        illegal_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] taken_cnt_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Counter is loaded with FLUSH_CYCLES-1 and the last flush cycle is the
    // one in which it reads 0, giving exactly FLUSH_CYCLES flush cycles.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [0:0]  state;
    logic [2:0]  flush_cnt;

    logic        resolvable;
    logic        funct3_rsvd;
    logic        br_cond;
    logic        taken;
    logic        tgt_misaligned;
    logic        branch_counted;

    assign br_unsign_o = funct3_i[1];

    // funct3 010 / 011 are reserved encodings for branches.
    assign funct3_rsvd = (funct3_i[2:1] == 2'b01);

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        br_cond = 1'b0;
        case (funct3_i)
            3'b000:          br_cond = br_equal_i;
            3'b001:          br_cond = ~br_equal_i;
            3'b100, 3'b110:  br_cond = br_less_i;
            3'b101, 3'b111:  br_cond = ~br_less_i;
            default:         br_cond = 1'b0;
        endcase
    end

    // JALR clears bit 0; branches and JAL are PC-relative.
    assign target_o = is_jalr_i ? (jalr_tgt_i & ~32'h1) : (pc_ex_i + imm_i);

    assign resolvable     = (state == ST_RUN) && valid_i && !stall_i && !rst_i;
    assign taken          = resolvable &&
                            (is_jal_i || is_jalr_i || (is_branch_i && br_cond));
    // Bit 0 is already handled (cleared or architecturally zero); bit 1 set
    // means the target is not word aligned, so the transfer is dropped.
    assign tgt_misaligned = target_o[1];
    assign redirect_o     = taken && !tgt_misaligned;
    assign branch_counted = resolvable && is_branch_i && !funct3_rsvd;

    assign flush_o = (state == ST_FLUSH);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching flop behaviour.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_o        <= RESET_PC;
            state       <= ST_RUN;
            flush_cnt   <= 3'd0;
            misalign_o  <= 1'b0;
            illegal_o   <= 1'b0;
            br_cnt_o    <= 32'd0;
            taken_cnt_o <= 32'd0;
        end else begin
            misalign_o <= taken && tgt_misaligned;
            illegal_o  <= resolvable && is_branch_i && funct3_rsvd;

            if (branch_counted) begin
                br_cnt_o <= br_cnt_o + 32'd1;
            end
            if (redirect_o && is_branch_i) begin
                taken_cnt_o <= taken_cnt_o + 32'd1;
            end

            case (state)
                ST_RUN: begin
                    if (redirect_o) begin
                        pc_o      <= target_o;
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else if (!stall_i) begin
                        pc_o <= pc_o + 32'd4;
                    end
                end
                default: begin
                    if (!stall_i) begin
                        pc_o <= pc_o + 32'd4;
                        if (flush_cnt == 3'd0) begin
                            state <= ST_RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//
// Self-checking bench for branch_resolve. A behavioural model predicts the
// combinational outputs each cycle and the registered state after each edge;
// the predicted registered state is queued before the edge and popped and
// compared after it. Directed scenarios add literal checks of key values.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        valid_i;
    logic        is_branch_i;
    logic        is_jal_i;
    logic        is_jalr_i;
    logic [2:0]  funct3_i;
    logic        br_less_i;
    logic        br_equal_i;
    logic [31:0] pc_ex_i;
    logic [31:0] imm_i;
    logic [31:0] jalr_tgt_i;
    logic        br_unsign_o;
    logic [31:0] pc_o;
    logic        redirect_o;
    logic [31:0] target_o;
    logic        flush_o;
    logic        misalign_o;
    logic        illegal_o;
    logic [31:0] br_cnt_o;
    logic [31:0] taken_cnt_o;

    branch_resolve #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .valid_i     (valid_i),
        .is_branch_i (is_branch_i),
        .is_jal_i    (is_jal_i),
        .is_jalr_i   (is_jalr_i),
        .funct3_i    (funct3_i),
        .br_less_i   (br_less_i),
        .br_equal_i  (br_equal_i),
        .pc_ex_i     (pc_ex_i),
        .imm_i       (imm_i),
        .jalr_tgt_i  (jalr_tgt_i),
        .br_unsign_o (br_unsign_o),
        .pc_o        (pc_o),
        .redirect_o  (redirect_o),
        .target_o    (target_o),
        .flush_o     (flush_o),
        .misalign_o  (misalign_o),
        .illegal_o   (illegal_o),
        .br_cnt_o    (br_cnt_o),
        .taken_cnt_o (taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic        ill;
        logic [31:0] br;
        logic [31:0] tk;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model state (what the bench believes the DUT holds).
    logic [31:0] m_pc    = 32'h0;
    logic        m_flush = 1'b0;
    logic [2:0]  m_cnt   = 3'd0;
    logic [31:0] m_br    = 32'h0;
    logic [31:0] m_tk    = 32'h0;

    task automatic set_idle();
        valid_i     = 1'b0;
        is_branch_i = 1'b0;
        is_jal_i    = 1'b0;
        is_jalr_i   = 1'b0;
        funct3_i    = 3'b000;
        br_less_i   = 1'b0;
        br_equal_i  = 1'b0;
        pc_ex_i     = 32'h0;
        imm_i       = 32'h0;
        jalr_tgt_i  = 32'h0;
    endtask

    task automatic drive(input logic b, input logic j, input logic jr,
                         input logic [2:0] f3, input logic lt, input logic eq,
                         input logic [31:0] pcx, input logic [31:0] imm,
                         input logic [31:0] jt);
        valid_i     = 1'b1;
        is_branch_i = b;
        is_jal_i    = j;
        is_jalr_i   = jr;
        funct3_i    = f3;
        br_less_i   = lt;
        br_equal_i  = eq;
        pc_ex_i     = pcx;
        imm_i       = imm;
        jalr_tgt_i  = jt;
    endtask

    // One clock: check combinational outputs against the model, queue the
    // predicted registered state, clock, then pop and compare.
    task automatic step(input string tag);
        logic        cond, resolv, tk, redir, rsvd;
        logic [31:0] tgt;
        exp_t        e, got;
        #1;
        case (funct3_i)
            3'b000: cond = br_equal_i;
            3'b001: cond = !br_equal_i;
            3'b100: cond = br_less_i;
            3'b110: cond = br_less_i;
            3'b101: cond = !br_less_i;
            3'b111: cond = !br_less_i;
            default: cond = 1'b0;
        endcase
        rsvd   = (funct3_i == 3'b010) || (funct3_i == 3'b011);
        tgt    = is_jalr_i ? {jalr_tgt_i[31:1], 1'b0} : pc_ex_i + imm_i;
        resolv = !m_flush && valid_i && !stall_i && !rst_i;
        tk     = resolv && (is_jal_i || is_jalr_i || (is_branch_i && cond));
        redir  = tk && !tgt[1];

        vec_cnt++;
        if (redirect_o !== redir) begin
            $display("FAIL %s redirect_o: got %b expected %b", tag, redirect_o, redir);
            err_cnt++;
        end
        vec_cnt++;
        if (target_o !== tgt) begin
            $display("FAIL %s target_o: got %h expected %h", tag, target_o, tgt);
            err_cnt++;
        end
        vec_cnt++;
        if (br_unsign_o !== funct3_i[1]) begin
            $display("FAIL %s br_unsign_o: got %b expected %b", tag, br_unsign_o, funct3_i[1]);
            err_cnt++;
        end

        e.tag = tag;
        if (rst_i) begin
            e.pc = RESET_PC; e.flush = 1'b0; e.cnt = 3'd0;
            e.mis = 1'b0; e.ill = 1'b0; e.br = 32'h0; e.tk = 32'h0;
        end else begin
            e.mis = tk && tgt[1];
            e.ill = resolv && is_branch_i && rsvd;
            e.br  = m_br + ((resolv && is_branch_i && !rsvd) ? 32'd1 : 32'd0);
            e.tk  = m_tk + ((redir && is_branch_i) ? 32'd1 : 32'd0);
            e.pc = m_pc; e.flush = m_flush; e.cnt = m_cnt;
            if (!m_flush) begin
                if (redir) begin
                    e.pc = tgt; e.flush = 1'b1; e.cnt = 3'd1;
                end else if (!stall_i) begin
                    e.pc = m_pc + 32'd4;
                end
            end else if (!stall_i) begin
                e.pc = m_pc + 32'd4;
                if (m_cnt == 3'd0) e.flush = 1'b0;
                else               e.cnt   = m_cnt - 3'd1;
            end
        end
        exp_q.push_back(e);

        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        got = e;
        got.pc = pc_o; got.flush = flush_o; got.mis = misalign_o;
        got.ill = illegal_o; got.br = br_cnt_o; got.tk = taken_cnt_o;
        vec_cnt++;
        if (got.pc !== e.pc || got.flush !== e.flush || got.mis !== e.mis ||
            got.ill !== e.ill || got.br !== e.br || got.tk !== e.tk) begin
            $display("FAIL %s state: got pc=%h fl=%b mis=%b ill=%b br=%0d tk=%0d expected pc=%h fl=%b mis=%b ill=%b br=%0d tk=%0d",
                     tag, got.pc, got.flush, got.mis, got.ill, got.br, got.tk,
                     e.pc, e.flush, e.mis, e.ill, e.br, e.tk);
            err_cnt++;
        end
        m_pc = e.pc; m_flush = e.flush; m_cnt = e.cnt; m_br = e.br; m_tk = e.tk;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        stall_i = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h40, 32'h80, 32'h0);
        #1;
        vec_cnt++;
        if (redirect_o !== 1'b0) begin
            $display("FAIL reset redirect_o: got %b expected 0", redirect_o);
            err_cnt++;
        end
        step("reset");
        rst_i = 1'b0;
        stall_i = 1'b0;
        set_idle();
        vec_cnt++;
        if (pc_o !== RESET_PC || flush_o !== 1'b0 || br_cnt_o !== 32'h0 || taken_cnt_o !== 32'h0) begin
            $display("FAIL reset_state: got pc=%h fl=%b br=%0d tk=%0d expected pc=%h fl=0 br=0 tk=0",
                     pc_o, flush_o, br_cnt_o, taken_cnt_o, RESET_PC);
            err_cnt++;
        end
        for (int i = 1; i <= 3; i++) begin
            step("free_run");
            vec_cnt++;
            if (pc_o !== 32'(4 * i)) begin
                $display("FAIL free_run pc_o: got %h expected %h", pc_o, 32'(4 * i));
                err_cnt++;
            end
        end
    endtask

    task automatic test_beq_taken();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h100, 32'h20, 32'h0);
        #1;
        vec_cnt++;
        if (redirect_o !== 1'b1 || target_o !== 32'h120) begin
            $display("FAIL beq_comb: got redir=%b tgt=%h expected redir=1 tgt=00000120", redirect_o, target_o);
            err_cnt++;
        end
        step("beq");
        set_idle();
        vec_cnt++;
        if (pc_o !== 32'h120 || flush_o !== 1'b1 || br_cnt_o !== 32'd1 || taken_cnt_o !== 32'd1) begin
            $display("FAIL beq_redirect: got pc=%h fl=%b br=%0d tk=%0d expected pc=00000120 fl=1 br=1 tk=1",
                     pc_o, flush_o, br_cnt_o, taken_cnt_o);
            err_cnt++;
        end
        step("beq_flush1");
        vec_cnt++;
        if (pc_o !== 32'h124 || flush_o !== 1'b1) begin
            $display("FAIL beq_flush1: got pc=%h fl=%b expected pc=00000124 fl=1", pc_o, flush_o);
            err_cnt++;
        end
        step("beq_flush2");
        vec_cnt++;
        if (pc_o !== 32'h128 || flush_o !== 1'b0) begin
            $display("FAIL beq_run: got pc=%h fl=%b expected pc=00000128 fl=0", pc_o, flush_o);
            err_cnt++;
        end
    endtask

    task automatic test_bltu_not_taken();
        drive(1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 32'h300, 32'h40, 32'h0);
        #1;
        vec_cnt++;
        if (redirect_o !== 1'b0 || br_unsign_o !== 1'b1) begin
            $display("FAIL bltu_comb: got redir=%b unsign=%b expected redir=0 unsign=1", redirect_o, br_unsign_o);
            err_cnt++;
        end
        step("bltu");
        set_idle();
        vec_cnt++;
        if (pc_o !== 32'h12c || br_cnt_o !== 32'd2 || taken_cnt_o !== 32'd1) begin
            $display("FAIL bltu_state: got pc=%h br=%0d tk=%0d expected pc=0000012c br=2 tk=1",
                     pc_o, br_cnt_o, taken_cnt_o);
            err_cnt++;
        end
    endtask

    task automatic test_jalr();
        drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h203);
        #1;
        vec_cnt++;
        if (target_o !== 32'h202 || redirect_o !== 1'b0) begin
            $display("FAIL jalr_mis_comb: got tgt=%h redir=%b expected tgt=00000202 redir=0", target_o, redirect_o);
            err_cnt++;
        end
        step("jalr_mis");
        set_idle();
        vec_cnt++;
        if (misalign_o !== 1'b1 || pc_o !== 32'h130 || br_cnt_o !== 32'd2 || taken_cnt_o !== 32'd1) begin
            $display("FAIL jalr_mis_state: got mis=%b pc=%h br=%0d tk=%0d expected mis=1 pc=00000130 br=2 tk=1",
                     misalign_o, pc_o, br_cnt_o, taken_cnt_o);
            err_cnt++;
        end
        step("jalr_mis_end");
        vec_cnt++;
        if (misalign_o !== 1'b0) begin
            $display("FAIL jalr_mis_pulse: got mis=%b expected 0", misalign_o);
            err_cnt++;
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h201);
        #1;
        vec_cnt++;
        if (target_o !== 32'h200 || redirect_o !== 1'b1) begin
            $display("FAIL jalr_comb: got tgt=%h redir=%b expected tgt=00000200 redir=1", target_o, redirect_o);
            err_cnt++;
        end
        step("jalr");
        set_idle();
        vec_cnt++;
        if (pc_o !== 32'h200 || br_cnt_o !== 32'd2 || taken_cnt_o !== 32'd1) begin
            $display("FAIL jalr_state: got pc=%h br=%0d tk=%0d expected pc=00000200 br=2 tk=1",
                     pc_o, br_cnt_o, taken_cnt_o);
            err_cnt++;
        end
        step("jalr_flush1");
        step("jalr_flush2");
    endtask

    task automatic test_stall_flush();
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h400, 32'h100, 32'h0);
        step("jal");
        // A valid, taken-looking branch is held on the inputs through FLUSH.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h800, 32'h10, 32'h0);
        stall_i = 1'b1;
        step("flush_stall");
        vec_cnt++;
        if (pc_o !== 32'h500 || flush_o !== 1'b1) begin
            $display("FAIL flush_stall: got pc=%h fl=%b expected pc=00000500 fl=1", pc_o, flush_o);
            err_cnt++;
        end
        stall_i = 1'b0;
        step("flush_a");
        vec_cnt++;
        if (pc_o !== 32'h504 || flush_o !== 1'b1) begin
            $display("FAIL flush_a: got pc=%h fl=%b expected pc=00000504 fl=1", pc_o, flush_o);
            err_cnt++;
        end
        step("flush_b");
        set_idle();
        vec_cnt++;
        if (pc_o !== 32'h508 || flush_o !== 1'b0 || br_cnt_o !== 32'd2) begin
            $display("FAIL flush_end: got pc=%h fl=%b br=%0d expected pc=00000508 fl=0 br=2",
                     pc_o, flush_o, br_cnt_o);
            err_cnt++;
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 32'h900, 32'h8, 32'h0);
        step("illegal_010");
        vec_cnt++;
        if (illegal_o !== 1'b1 || br_cnt_o !== 32'd2) begin
            $display("FAIL illegal_010: got ill=%b br=%0d expected ill=1 br=2", illegal_o, br_cnt_o);
            err_cnt++;
        end
        funct3_i = 3'b011;
        step("illegal_011");
        set_idle();
        step("illegal_end");
        vec_cnt++;
        if (illegal_o !== 1'b0) begin
            $display("FAIL illegal_pulse: got ill=%b expected 0", illegal_o);
            err_cnt++;
        end
    endtask

    task automatic test_pc_wrap();
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'hffff_ff00, 32'h0000_00fc, 32'h0);
        step("wrap_jal");
        set_idle();
        step("wrap_flush1");
        vec_cnt++;
        if (pc_o !== 32'h0) begin
            $display("FAIL pc_wrap: got pc=%h expected 00000000", pc_o);
            err_cnt++;
        end
        step("wrap_flush2");
        drive(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 32'hffff_fff0, 32'h20, 32'h0);
        #1;
        vec_cnt++;
        if (target_o !== 32'h10 || redirect_o !== 1'b1) begin
            $display("FAIL tgt_wrap: got tgt=%h redir=%b expected tgt=00000010 redir=1", target_o, redirect_o);
            err_cnt++;
        end
        step("wrap_bne");
        set_idle();
        step("wrap_bne_f1");
        step("wrap_bne_f2");
    endtask

    task automatic test_reset_in_flush();
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h580, 32'h80, 32'h0);
        step("rif_jal");
        set_idle();
        rst_i = 1'b1;
        step("rif_reset");
        rst_i = 1'b0;
        vec_cnt++;
        if (pc_o !== RESET_PC || flush_o !== 1'b0) begin
            $display("FAIL reset_in_flush: got pc=%h fl=%b expected pc=%h fl=0", pc_o, flush_o, RESET_PC);
            err_cnt++;
        end
        step("rif_run");
        vec_cnt++;
        if (pc_o !== 32'h4 || flush_o !== 1'b0) begin
            $display("FAIL reset_in_flush_run: got pc=%h fl=%b expected pc=00000004 fl=0", pc_o, flush_o);
            err_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int unsigned cls;
        for (int i = 0; i < 300; i++) begin
            cls = $urandom_range(0, 3);
            drive(cls == 1, cls == 2, cls == 3, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, {$urandom_range(0, 255), 2'b00} - 32'd512, $urandom);
            valid_i = ($urandom_range(0, 7) != 0);
            stall_i = ($urandom_range(0, 3) == 0);
            rst_i   = ($urandom_range(0, 63) == 0);
            step("random");
        end
        rst_i = 1'b0;
        stall_i = 1'b0;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst_i   = 1'b1;
        stall_i = 1'b0;
        test_reset();
        test_beq_taken();
        test_bltu_not_taken();
        test_jalr();
        test_stall_flush();
        test_illegal();
        test_pc_wrap();
        test_reset_in_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 RESET_PC, 32'h0000_0000, value loaded into the fetch PC on reset.
REQ-002 FLUSH_CYCLES, 2, number of cycles flush_o stays high after a redirect; legal range 1-7.
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 stall_i  input  1  pipeline hold: freezes the PC, suppresses resolution, and freezes the flush counter.
REQ-006 valid_i  input  1  the EX-stage instruction is valid.
REQ-007 is_branch_i / is_jal_i / is_jalr_i  input  1 each  EX instruction class; at most one is high.
REQ-008 funct3_i  input  3  branch condition code.
REQ-009 br_less_i, br_equal_i  input  1 each  comparator flags for rs1 against rs2.
REQ-010 pc_ex_i  input  32  PC of the EX instruction.
REQ-011 imm_i  input  32  sign-extended branch or JAL offset.
REQ-012 jalr_tgt_i  input  32  rs1+imm sum from the ALU.
REQ-013 br_unsign_o  output  1  comparator mode select.
REQ-014 pc_o  output  32  registered fetch PC.
REQ-015 redirect_o  output  1  combinational; high when a control transfer is taken this cycle.
REQ-016 target_o  output  32  combinational resolved target.
REQ-017 flush_o  output  1  registered; squash the IF and ID slots.
REQ-018 misalign_o  output  1  registered one-cycle pulse for a misaligned target.
REQ-019 illegal_o  output  1  registered one-cycle pulse for a branch with funct3 equal to 010 or 011.
REQ-020 br_cnt_o, taken_cnt_o  output  32 each  performance counters for resolved branches and taken branches.

Function
REQ-021 br_unsign_o SHALL be funct3_i[1], and SHALL be combinational.
REQ-022 Branch condition SHALL be decoded from funct3_i as follows: 000 is equal; 001 is not equal; 100 and 110 are less; 101 and 111 are not less; 010 and 011 are never taken.
REQ-023 The branch and JAL target SHALL be pc_ex_i + imm_i modulo 2^32. The JALR target SHALL be jalr_tgt_i with bit 0 cleared.
REQ-024 A transfer is resolvable only when all three hold: state is RUN, valid_i=1, and stall_i=0. In any other case redirect_o=0 and the counters hold.
REQ-025 A resolvable transfer is taken when either holds: the instruction is JAL or JALR; or it is a branch whose condition is true.
REQ-026 A taken transfer whose target has bit 1 set SHALL NOT assert redirect_o; misalign_o SHALL pulse the next cycle and the PC SHALL advance by 4.
REQ-027 A resolvable branch with funct3 010 or 011 SHALL pulse illegal_o the next cycle; it is not taken and not counted.
REQ-028 FSM states SHALL be RUN and FLUSH.
REQ-029 RUN -> FLUSH SHALL occur on redirect_o=1. At that edge: pc_o <= target_o; the counter <= FLUSH_CYCLES-1.
REQ-030 In FLUSH, flush_o=1.
REQ-031 In FLUSH, valid_i SHALL be ignored.
REQ-032 In FLUSH with stall_i=0: pc_o SHALL advance by 4 and the counter SHALL decrement. The FSM SHALL return to RUN after the cycle in which the counter is 0.
REQ-033 In FLUSH with stall_i=1, the PC and the counter SHALL hold.
REQ-034 In RUN with no redirect: pc_o SHALL advance by 4 when stall_i=0 and hold when stall_i=1.
REQ-035 flush_o SHALL be 0 in RUN, so a redirect gives exactly FLUSH_CYCLES unstalled flush cycles.
REQ-036 br_cnt_o SHALL increment on every resolvable legal branch, taken or not.
REQ-037 taken_cnt_o SHALL increment on every redirect caused by a branch. JAL, JALR and misaligned targets are excluded.
REQ-038 Both counters SHALL wrap from all-ones to 0.
REQ-039 PC arithmetic SHALL wrap modulo 2^32.

Reset
REQ-040 With rst_i=1 at an edge, the next-cycle values SHALL be: pc_o=RESET_PC; state RUN; counter 0; flush_o=0; misalign_o=0; illegal_o=0; both counters 0.
REQ-041 Reset SHALL take priority over stall_i, redirect and FLUSH. A reset during FLUSH ends the flush immediately.
REQ-042 While rst_i=1, redirect_o SHALL be forced to 0.

Verification
REQ-043 Reset then 3 free cycles -> pc_o sequence 0, 4, 8, 12. Both counters are 0.
REQ-044 BEQ at pc_ex 0x100, imm 0x20, br_equal_i=1 -> in the same cycle redirect_o=1 and target_o=0x120. Next: pc_o=0x120, flush_o=1 for 2 cycles, pc_o=0x124, 0x128, then RUN. br_cnt_o=1, taken_cnt_o=1.
REQ-045 BLTU with br_less_i=0 -> redirect_o=0, br_unsign_o=1, PC+4, br_cnt_o increments, taken_cnt_o unchanged.
REQ-046 JALR with jalr_tgt_i=0x203 -> target_o=0x202, misalign_o pulses, no redirect. With jalr_tgt_i=0x201 -> target 0x200, redirect. Counters unchanged in both cases.
REQ-047 Redirect, then stall_i=1 in the first FLUSH cycle -> flush_o stays high and PC holds. Flush ends after 2 unstalled cycles. A valid branch presented during FLUSH is ignored.
REQ-048 rst_i asserted during FLUSH -> next cycle pc_o=RESET_PC, flush_o=0, state RUN.
